// File: rtl/lattice_pkg.sv
// Shared definitions for the lattice pricing blocks.
// Holds bus widths, the generator's wren delay-line depth and the job
// controller state encoding.
package lattice_pkg;

    localparam int unsigned N_W          = 16;
    localparam int unsigned ADDR_W       = 11;
    localparam int unsigned GEN_PIPE_DLY = 30;
    localparam int unsigned CYC_W        = 32;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_ARM    = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } job_state_e;

endpackage

// File: rtl/lattice_job_ctrl_if.sv
// Bus bundle between the lattice job controller and its environment.
// Carries the job handshake (job_valid/job_n/job_ready), the generator
// side (start/n_out out, wren/wraddr/wrdata in), the result handshake
// (res_valid/res_ready/res_price/res_cycles) and status (err_n,
// err_timeout, busy).
// slave  : the controller's view.
// master : the host / generator / consumer view.
interface lattice_job_ctrl_if
    import lattice_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) ();

    logic              job_valid;
    logic [N_W-1:0]    job_n;
    logic              job_ready;
    logic              start;
    logic [N_W-1:0]    n_out;
    logic              wren;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] wrdata;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_price;
    logic [CYC_W-1:0]  res_cycles;
    logic              err_n;
    logic              err_timeout;
    logic              busy;

    modport slave (
        input  job_valid, job_n, wren, wraddr, wrdata, res_ready,
        output job_ready, start, n_out, res_valid, res_price, res_cycles,
               err_n, err_timeout, busy
    );

    modport master (
        output job_valid, job_n, wren, wraddr, wrdata, res_ready,
        input  job_ready, start, n_out, res_valid, res_price, res_cycles,
               err_n, err_timeout, busy
    );

endinterface

// File: rtl/lattice_n_check.sv
// Combinational legality check of a lattice step count.
// Ports: n_i (step count), legal_c (1 when N_MIN <= n <= N_MAX and n is a
// multiple of 4).
module lattice_n_check
    import lattice_pkg::*;
#(
    parameter int unsigned N_MIN = 132,
    parameter int unsigned N_MAX = 2044
) (
    input  logic [N_W-1:0] n_i,
    output logic           legal_c
);

    assign legal_c = (n_i >= N_W'(N_MIN)) && (n_i <= N_W'(N_MAX)) && (n_i[1:0] == 2'b00);

endmodule

// File: rtl/lattice_job_ctrl.sv
// Job controller in front of the lattice address generator.
// Accepts a job, validates n, pulses start, holds n_out, tracks the
// generator's wren window, captures the root price (wraddr 0) and returns
// price plus run-cycle count on a result handshake.
// Ports: clk, nrst (synchronous, active-low), bus (controller side of
// lattice_job_ctrl_if).
module lattice_job_ctrl
    import lattice_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SETTLE      = 32,
    parameter int unsigned ARM_TIMEOUT = 64,
    parameter int unsigned N_MIN       = 132,
    parameter int unsigned N_MAX       = 2044
) (
    input  logic              clk,
    input  logic              nrst,
    lattice_job_ctrl_if.slave bus
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
    localparam int unsigned ARM_W    = $clog2(ARM_TIMEOUT + 1);

    job_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ARM_W-1:0]    arm_q, arm_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [DATA_W-1:0]   price_q, price_d;
    logic [CYC_W-1:0]    res_cycles_q, res_cycles_d;
    logic                err_n_q, err_n_d;
    logic                err_to_q, err_to_d;
    logic                job_ready_q, start_q, res_valid_q, busy_q;
    logic                n_legal_c;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    lattice_n_check #(
        .N_MIN (N_MIN),
        .N_MAX (N_MAX)
    ) u_n_check (
        .n_i     (bus.job_n),
        .legal_c (n_legal_c)
    );

    // Next-state and counter logic.
    // Arm and cycle counters are loaded with 1 in LAUNCH so that in every
    // later cycle they equal the number of cycles elapsed since the start
    // pulse; timeout and res_cycles then read straight off them.
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        arm_d        = arm_q;
        cyc_d        = cyc_q;
        n_d          = n_q;
        price_d      = price_q;
        res_cycles_d = res_cycles_q;
        err_n_d      = 1'b0;
        err_to_d     = 1'b0;

        unique case (state_q)
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE)) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.job_valid && job_ready_q) begin
                    if (n_legal_c) begin
                        n_d     = bus.job_n;
                        state_d = ST_LAUNCH;
                    end else begin
                        err_n_d = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                arm_d   = ARM_W'(1);
                cyc_d   = CYC_W'(1);
                state_d = ST_ARM;
            end
            ST_ARM: begin
                cyc_d = sat_inc(cyc_q);
                if (bus.wren) begin
                    state_d = ST_RUN;
                end else if (arm_q == ARM_W'(ARM_TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.wren) begin
                    cyc_d = sat_inc(cyc_q);
                    // Root node: the last write to address 0 is the price.
                    if (bus.wraddr == '0) begin
                        price_d = bus.wrdata;
                    end
                end else begin
                    res_cycles_d = cyc_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    // job_ready drops for the cycle err_n is reported so a held request is
    // not re-evaluated back to back.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_SETTLE;
            settle_q     <= '0;
            arm_q        <= '0;
            cyc_q        <= '0;
            n_q          <= '0;
            price_q      <= '0;
            res_cycles_q <= '0;
            err_n_q      <= 1'b0;
            err_to_q     <= 1'b0;
            job_ready_q  <= 1'b0;
            start_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            arm_q        <= arm_d;
            cyc_q        <= cyc_d;
            n_q          <= n_d;
            price_q      <= price_d;
            res_cycles_q <= res_cycles_d;
            err_n_q      <= err_n_d;
            err_to_q     <= err_to_d;
            job_ready_q  <= (state_d == ST_IDLE) && !err_n_d;
            start_q      <= (state_d == ST_LAUNCH);
            res_valid_q  <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign bus.job_ready   = job_ready_q;
    assign bus.start       = start_q;
    assign bus.n_out       = n_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_price   = price_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.err_n       = err_n_q;
    assign bus.err_timeout = err_to_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_lattice_job_ctrl.sv
// Directed bench for lattice_job_ctrl with a behavioural generator model:
// wren rises GEN_PIPE_DLY+1 cycles after start, stays high for w cycles
// writing addresses (w-1-i)%5 (last write always at address 0), and wren
// reads 1 for GEN_PIPE_DLY cycles after a reset.
module tb_lattice_job_ctrl;
    import lattice_pkg::*;

    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic nrst;
    int   errors = 0;
    int   checks = 0;
    int   start_seen = 0;

    always #5 clk = ~clk;

    lattice_job_ctrl_if #(.DATA_W(DATA_W)) bus ();

    lattice_job_ctrl #(
        .DATA_W      (DATA_W),
        .SETTLE      (32),
        .ARM_TIMEOUT (64),
        .N_MIN       (132),
        .N_MAX       (2044)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always @(negedge clk) if (bus.start === 1'b1) start_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] data_of(input int n, input int i);
        return 32'h1000_0000 + 32'(n * 1000) + 32'(i * 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job once job_ready is seen; leaves the bench in the start cycle.
    task automatic launch(input int n);
        int waited = 0;
        while (bus.job_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL launch_ready n=%0d: job_ready=%b after %0d cycles, required 1", n, bus.job_ready, waited);
        end
        bus.job_valid = 1'b1;
        bus.job_n     = 16'(n);
        tick();
        bus.job_valid = 1'b0;
        checks++;
        if (bus.start !== 1'b1 || bus.n_out !== 16'(n)) begin
            errors++;
            $display("FAIL launch_start n=%0d: start=%b n_out=%0d, required start=1 n_out=%0d", n, bus.start, bus.n_out, n);
        end
    endtask

    // Generator model from the start cycle; returns early (wren still 1) at abort_at.
    task automatic gen_run(input int w, input int abort_at);
        repeat (GEN_PIPE_DLY) tick();
        for (int i = 0; i < w; i++) begin
            if (i == abort_at) return;
            tick();
            bus.wren   = 1'b1;
            bus.wraddr = 11'((w - 1 - i) % 5);
            bus.wrdata = data_of(w, i);
        end
        tick();
        bus.wren = 1'b0;
    endtask

    task automatic test_reset();
        nrst          = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_n     = '0;
        bus.res_ready = 1'b0;
        bus.wren      = 1'b1;
        bus.wraddr    = '0;
        bus.wrdata    = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++;
        if ({bus.job_ready, bus.start, bus.res_valid, bus.err_n, bus.err_timeout} !== 5'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: rdy/st/rv/en/et=%b busy=%b, required 00000 busy=1",
                     {bus.job_ready, bus.start, bus.res_valid, bus.err_n, bus.err_timeout}, bus.busy);
        end
        checks++;
        if (bus.n_out !== '0 || bus.res_price !== '0 || bus.res_cycles !== '0) begin
            errors++;
            $display("FAIL reset_data: n_out=%0d price=%h cycles=%0d, required 0/0/0", bus.n_out, bus.res_price, bus.res_cycles);
        end
        nrst = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == GEN_PIPE_DLY) bus.wren = 1'b0;
            checks++;
            if (bus.job_ready !== (k == 33) || bus.busy !== (k != 33)) begin
                errors++;
                $display("FAIL settle_k%0d: job_ready=%b busy=%b, required %b/%b", k, bus.job_ready, bus.busy, k == 33, k != 33);
            end
        end
        checks++;
        if (bus.res_price !== '0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL settle_wren_ignored: price=%h res_valid=%b, required 0/0", bus.res_price, bus.res_valid);
        end
    endtask

    task automatic test_illegal_n();
        int bad_n[3] = '{100, 258, 2048};
        int s0 = start_seen;
        foreach (bad_n[j]) begin
            bus.job_valid = 1'b1;
            bus.job_n     = 16'(bad_n[j]);
            tick();
            bus.job_valid = 1'b0;
            checks++;
            if (bus.err_n !== 1'b1 || bus.job_ready !== 1'b0 || bus.err_timeout !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse n=%0d: err_n=%b job_ready=%b err_timeout=%b, required 1/0/0",
                         bad_n[j], bus.err_n, bus.job_ready, bus.err_timeout);
            end
            tick();
            checks++;
            if (bus.err_n !== 1'b0 || bus.job_ready !== 1'b1 || bus.n_out !== '0) begin
                errors++;
                $display("FAIL illegal_after n=%0d: err_n=%b job_ready=%b n_out=%0d, required 0/1/0",
                         bad_n[j], bus.err_n, bus.job_ready, bus.n_out);
            end
        end
        checks++;
        if (start_seen != s0) begin
            errors++;
            $display("FAIL illegal_no_start: start pulses=%0d, required 0", start_seen - s0);
        end
    endtask

    task automatic test_single_job();
        int s0 = start_seen;
        launch(256);
        gen_run(64, -1);
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_price !== data_of(64, 63) || bus.res_cycles !== 32'd95) begin
            errors++;
            $display("FAIL job256_result: valid=%b price=%h cycles=%0d, required 1/%h/95",
                     bus.res_valid, bus.res_price, bus.res_cycles, data_of(64, 63));
        end
        checks++;
        if (bus.job_ready !== 1'b0 || bus.busy !== 1'b1 || start_seen - s0 != 1) begin
            errors++;
            $display("FAIL job256_status: job_ready=%b busy=%b starts=%0d, required 0/1/1", bus.job_ready, bus.busy, start_seen - s0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1 || bus.n_out !== 16'd256) begin
            errors++;
            $display("FAIL job256_accept: res_valid=%b job_ready=%b n_out=%0d, required 0/1/256",
                     bus.res_valid, bus.job_ready, bus.n_out);
        end
    endtask

    task automatic test_backpressure();
        launch(256);
        gen_run(64, -1);
        tick();
        for (int k = 0; k < 10; k++) begin
            // Stray writes to the root address while DONE must be ignored.
            bus.wren   = 1'b1;
            bus.wraddr = '0;
            bus.wrdata = 32'h0BAD_0000 + 32'(k);
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_price !== data_of(64, 63) || bus.res_cycles !== 32'd95 || bus.job_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_k%0d: valid=%b price=%h cycles=%0d job_ready=%b, required 1/%h/95/0",
                         k, bus.res_valid, bus.res_price, bus.res_cycles, bus.job_ready, data_of(64, 63));
            end
            tick();
        end
        bus.wren      = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: res_valid=%b job_ready=%b, required 0/1", bus.res_valid, bus.job_ready);
        end
    endtask

    task automatic test_timeout();
        int s0 = start_seen;
        launch(256);
        for (int k = 1; k <= 63; k++) begin
            tick();
            checks++;
            if (bus.err_timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early k=%0d: err_timeout=%b, required 0", k, bus.err_timeout);
            end
        end
        tick();
        checks++;
        if (bus.err_timeout !== 1'b1 || bus.err_n !== 1'b0 || bus.busy !== 1'b0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: err_timeout=%b err_n=%b busy=%b job_ready=%b, required 1/0/0/1",
                     bus.err_timeout, bus.err_n, bus.busy, bus.job_ready);
        end
        tick();
        checks++;
        if (bus.err_timeout !== 1'b0 || bus.res_valid !== 1'b0 || start_seen - s0 != 1) begin
            errors++;
            $display("FAIL timeout_after: err_timeout=%b res_valid=%b starts=%0d, required 0/0/1",
                     bus.err_timeout, bus.res_valid, start_seen - s0);
        end
    endtask

    task automatic test_reset_mid_run();
        bit rv_seen = 1'b0;
        int s0;
        launch(2044);
        gen_run(511, 200);
        nrst       = 1'b0;
        bus.wraddr = '0;
        bus.wrdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({bus.job_ready, bus.start, bus.res_valid, bus.err_n, bus.err_timeout} !== 5'b0 ||
            bus.n_out !== '0 || bus.res_price !== '0 || bus.res_cycles !== '0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: flags=%b n_out=%0d price=%h cycles=%0d busy=%b, required 0/0/0/0 busy=1",
                     {bus.job_ready, bus.start, bus.res_valid, bus.err_n, bus.err_timeout},
                     bus.n_out, bus.res_price, bus.res_cycles, bus.busy);
        end
        nrst = 1'b1;
        s0   = start_seen;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == GEN_PIPE_DLY) bus.wren = 1'b0;
            if (bus.res_valid === 1'b1) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen || start_seen != s0 || bus.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet: res_valid_seen=%b starts=%0d job_ready=%b, required 0/0/1",
                     rv_seen, start_seen - s0, bus.job_ready);
        end
        launch(132);
        gen_run(33, -1);
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_price !== data_of(33, 32) || bus.res_cycles !== 32'd64) begin
            errors++;
            $display("FAIL job132_result: valid=%b price=%h cycles=%0d, required 1/%h/64",
                     bus.res_valid, bus.res_price, bus.res_cycles, data_of(33, 32));
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1 || bus.n_out !== 16'd132) begin
            errors++;
            $display("FAIL job132_accept: res_valid=%b job_ready=%b n_out=%0d, required 0/1/132",
                     bus.res_valid, bus.job_ready, bus.n_out);
        end
    endtask

    initial begin
        test_reset();
        test_illegal_n();
        test_single_job();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
